// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

   localparam logic [6:0]  Funct7Mext = 7'b000_0001;
   localparam logic [31:0] DivByZero  = 32'hFFFF_FFFF;
   localparam logic [31:0] IntMin     = 32'h8000_0000;

   typedef enum logic [2:0] {
      MD_MUL    = 3'b000,
      MD_MULH   = 3'b001,
      MD_MULHSU = 3'b010,
      MD_MULHU  = 3'b011,
      MD_DIV    = 3'b100,
      MD_DIVU   = 3'b101,
      MD_REM    = 3'b110,
      MD_REMU   = 3'b111
   } md_op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_DONE
   } state_t;

   function automatic logic [31:0] abs_val(input logic [31:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

endpackage

// File: rtl/ex_muldiv.sv
// Iterative RV32M multiply/divide: radix-2 shift-add multiply and restoring divide,
// one bit per cycle, stalling the upstream pipeline while busy.
module ex_muldiv
   import muldiv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_start,
   input  logic [2:0]      i_funct3,
   input  logic [XLEN-1:0] i_rs1_data,
   input  logic [XLEN-1:0] i_rs2_data,
   input  logic            i_flush,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   localparam int unsigned CntW = $clog2(XLEN);

   state_t            state_q;
   md_op_t            op_q;
   logic              neg_a_q, neg_b_q;
   logic [CntW-1:0]   cnt_q;
   logic [2*XLEN-1:0] acc_q;
   logic [XLEN-1:0]   rem_q, b_q;

   md_op_t            op_in;
   logic              a_sgn, b_sgn, neg_a, neg_b;
   logic [XLEN-1:0]   abs_a, abs_b;
   logic              div_zero, div_ovf, special;
   logic [XLEN-1:0]   special_res;

   always_comb begin
      op_in = md_op_t'(i_funct3);
      a_sgn = 1'b0;
      b_sgn = 1'b0;
      unique case (op_in)
         MD_MUL, MD_MULH, MD_DIV, MD_REM: begin
            a_sgn = 1'b1;
            b_sgn = 1'b1;
         end
         MD_MULHSU: a_sgn = 1'b1;
         default: ;
      endcase
      neg_a    = a_sgn & i_rs1_data[XLEN-1];
      neg_b    = b_sgn & i_rs2_data[XLEN-1];
      abs_a    = abs_val(i_rs1_data, neg_a);
      abs_b    = abs_val(i_rs2_data, neg_b);
      div_zero = i_funct3[2] & (i_rs2_data == '0);
      div_ovf  = a_sgn & i_funct3[2] & (i_rs1_data == IntMin) & (i_rs2_data == '1);
      special  = div_zero | div_ovf;
      // funct3[1] separates REM* from DIV* within the divide group
      if (div_zero) special_res = i_funct3[1] ? i_rs1_data : DivByZero;
      else          special_res = i_funct3[1] ? '0 : IntMin;
   end

   logic [XLEN:0]     mul_sum, rem_sh, diff;
   logic [2*XLEN-1:0] mul_next, prod;
   logic              q_bit;
   logic [XLEN-1:0]   rem_next, quo_next, quo_f, rem_f, calc_res;

   always_comb begin
      mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      mul_next = {mul_sum, acc_q[XLEN-1:1]};
      // Dividend bits enter the remainder MSB-first; quotient bits fill acc from the bottom
      rem_sh   = {rem_q, acc_q[XLEN-1]};
      diff     = rem_sh - {1'b0, b_q};
      q_bit    = ~diff[XLEN];
      rem_next = q_bit ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
      quo_next = {acc_q[XLEN-2:0], q_bit};
      prod     = (neg_a_q ^ neg_b_q) ? -mul_next : mul_next;
      quo_f    = (neg_a_q ^ neg_b_q) ? -quo_next : quo_next;
      rem_f    = neg_a_q ? -rem_next : rem_next;
      unique case (op_q)
         MD_MUL:                        calc_res = prod[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU:  calc_res = prod[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:               calc_res = quo_f;
         default:                       calc_res = rem_f;
      endcase
   end

   assign o_busy = ~i_rst & ((state_q == S_CALC) |
                             ((state_q == S_IDLE) & i_start & ~i_flush));

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q  <= S_IDLE;
         op_q     <= MD_MUL;
         neg_a_q  <= 1'b0;
         neg_b_q  <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         rem_q    <= '0;
         b_q      <= '0;
         o_result <= '0;
         o_done   <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (i_flush) begin
            state_q <= S_IDLE;
         end else begin
            unique case (state_q)
               S_IDLE: begin
                  if (i_start) begin
                     op_q    <= op_in;
                     neg_a_q <= neg_a;
                     neg_b_q <= neg_b;
                     b_q     <= abs_b;
                     rem_q   <= '0;
                     acc_q   <= {{XLEN{1'b0}}, abs_a};
                     cnt_q   <= CntW'(XLEN - 1);
                     if (special) begin
                        o_result <= special_res;
                        o_done   <= 1'b1;
                        state_q  <= S_DONE;
                     end else begin
                        state_q  <= S_CALC;
                     end
                  end
               end
               S_CALC: begin
                  acc_q <= op_q[2] ? {{XLEN{1'b0}}, quo_next} : mul_next;
                  rem_q <= rem_next;
                  cnt_q <= cnt_q - 1'b1;
                  if (cnt_q == '0) begin
                     o_result <= calc_res;
                     o_done   <= 1'b1;
                     state_q  <= S_DONE;
                  end
               end
               default: state_q <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv with a per-cycle arithmetic reference model.
module tb_ex_muldiv;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        flush = 1'b0;
   logic [2:0]  f3 = 3'b000;
   logic [31:0] rs1 = '0;
   logic [31:0] rs2 = '0;
   logic        busy, done;
   logic [31:0] result;

   int n_checks = 0;
   int n_pass = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   ex_muldiv #(.XLEN(32)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_start    (start),
      .i_funct3   (f3),
      .i_rs1_data (rs1),
      .i_rs2_data (rs2),
      .i_flush    (flush),
      .o_busy     (busy),
      .o_done     (done),
      .o_result   (result)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Reference result straight from RV32M arithmetic rules
   function automatic logic [31:0] ref_fn(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
      int          sa, sb;
      longint      pa, pb, ps;
      logic [63:0] p;
      sa = a;
      sb = b;
      case (f)
         3'd0, 3'd1: begin
            pa = longint'(sa); pb = longint'(sb); ps = pa * pb; p = ps;
            return (f == 3'd0) ? p[31:0] : p[63:32];
         end
         3'd2: begin
            pa = longint'(sa); pb = longint'({32'b0, b}); ps = pa * pb; p = ps;
            return p[63:32];
         end
         3'd3: begin
            p = {32'b0, a} * {32'b0, b};
            return p[63:32];
         end
         3'd4: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
            return sa / sb;
         end
         3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return sa % sb;
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a,
                                  input logic [31:0] b);
      if (f[2] && b == 0) return 1;
      if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
   endfunction

   // Model: a start accepted in cycle c finishes in cycle c+lat; busy covers c..c+lat-1
   bit          m_pending = 0;
   int          m_done_at = 0;
   logic [31:0] m_val = '0;
   logic [31:0] m_last = '0;

   always @(negedge clk) begin
      logic eb, ed;
      eb = 1'b0;
      ed = 1'b0;
      if (rst) begin
         m_pending = 0;
         m_last    = '0;
      end else begin
         if (!m_pending && start && !flush) begin
            m_pending = 1;
            m_done_at = cyc + ref_lat(f3, rs1, rs2);
            m_val     = ref_fn(f3, rs1, rs2);
         end
         eb = m_pending && (cyc < m_done_at);
         ed = m_pending && (cyc == m_done_at);
         if (ed) m_last = m_val;
      end
      chk("model_busy", {31'b0, busy}, {31'b0, eb});
      chk("model_done", {31'b0, done}, {31'b0, ed});
      chk("model_result", result, m_last);
      if (!rst && m_pending && (ed || flush)) m_pending = 0;
   end

   task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat_exp,
                         input int glitch_at);
      int lat;
      bit seen;
      @(posedge clk); #1;
      start = 1'b1; f3 = f; rs1 = a; rs2 = b;
      seen = 0;
      lat = 0;
      while (!seen && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         start = (lat == glitch_at);
         if (start) begin
            f3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
         end
         if (done) seen = 1;
      end
      start = 1'b0;
      chk({name, "_done_seen"}, 32'(seen), 32'd1);
      chk({name, "_latency"}, 32'(lat), 32'(lat_exp));
      chk({name, "_result"}, result, exp);
   endtask

   task automatic no_done_window(input string name, input int n);
      int cnt;
      cnt = 0;
      repeat (n) begin
         @(posedge clk); #1;
         if (done) cnt++;
      end
      chk(name, 32'(cnt), 32'd0);
   endtask

   typedef struct {
      string       name;
      logic [2:0]  f;
      logic [31:0] a, b, exp;
      int          lat;
   } vec_t;

   vec_t vecs[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
      $fatal(1);
   end

   initial begin
      vecs.push_back('{"mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33});
      vecs.push_back('{"mulh_min_min",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33});
      vecs.push_back('{"mulhu_max",     3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33});
      vecs.push_back('{"mulhsu_m1",     3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33});
      vecs.push_back('{"div_m7_2",      3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33});
      vecs.push_back('{"rem_m7_2",      3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33});
      vecs.push_back('{"divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        33});
      vecs.push_back('{"remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         33});
      vecs.push_back('{"div_7_m3",      3'd4, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFE, 33});
      vecs.push_back('{"rem_7_m3",      3'd6, 32'd7,          32'hFFFF_FFFD, 32'd1,         33});
      vecs.push_back('{"mul_hi_zero",   3'd0, 32'h0001_0000,  32'h0001_0000, 32'd0,         33});
      vecs.push_back('{"divu_max_1",    3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 33});
      vecs.push_back('{"div_5_0",       3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1});
      vecs.push_back('{"remu_5_0",      3'd7, 32'd5,          32'd0,         32'd5,         1});
      vecs.push_back('{"div_ovf",       3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1});
      vecs.push_back('{"rem_ovf",       3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1});

      // Reset with start held high: busy must stay forced low
      start = 1'b1; f3 = 3'd0; rs1 = 32'd3; rs2 = 32'd4;
      @(posedge clk); #1;
      chk("reset_busy", {31'b0, busy}, 32'd0);
      chk("reset_done", {31'b0, done}, 32'd0);
      chk("reset_result", result, 32'd0);
      @(posedge clk); #1;
      start = 1'b0;
      rst = 1'b0;

      foreach (vecs[i])
         run_op(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 0);

      // Stray start during CALC is ignored
      run_op("ignore_start", 3'd5, 32'd100, 32'd7, 32'd14, 33, 5);

      // Flush mid-CALC
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'd5; rs1 = 32'd1000; rs2 = 32'd3;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flush_busy_after", {31'b0, busy}, 32'd0);
      no_done_window("flush_no_done", 40);
      chk("flush_result_held", result, 32'd14);

      // Start and flush together
      @(posedge clk); #1;
      start = 1'b1; flush = 1'b1; f3 = 3'd0; rs1 = 32'd2; rs2 = 32'd3;
      #1 chk("start_flush_busy", {31'b0, busy}, 32'd0);
      @(posedge clk); #1;
      start = 1'b0; flush = 1'b0;
      no_done_window("start_flush_no_done", 40);

      // Reset mid-CALC
      @(posedge clk); #1;
      start = 1'b1; f3 = 3'd0; rs1 = 32'd7; rs2 = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (14) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      chk("midrst_busy", {31'b0, busy}, 32'd0);
      chk("midrst_done", {31'b0, done}, 32'd0);
      chk("midrst_result", result, 32'd0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      no_done_window("midrst_no_done", 40);

      run_op("after_reset", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 33, 0);

      repeat (3) @(posedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
